// File: rtl/fir_mul_pkg.sv
// Shared sizing, limit and rounding helpers for the FIR multiply/accumulate datapath.
// Limits travel in a fixed 64-bit signed container, so output widths up to 62 bits are covered.
package fir_mul_pkg;

   localparam int LIM_W = 64;
   typedef logic signed [LIM_W-1:0] lim_t;
   localparam lim_t LIM_ONE  = lim_t'(1);
   localparam lim_t LIM_ZERO = lim_t'(0);

   // Full-precision product width once both operands are extended to a common signed form.
   function automatic int prod_width(input int w0, input int w1);
      return w0 + w1 + 1;
   endfunction

   function automatic lim_t lim_max(input int w, input bit is_signed);
      if (is_signed) return (LIM_ONE <<< (w - 1)) - LIM_ONE;
      return (LIM_ONE <<< w) - LIM_ONE;
   endfunction

   function automatic lim_t lim_min(input int w, input bit is_signed);
      if (is_signed) return -(LIM_ONE <<< (w - 1));
      return LIM_ZERO;
   endfunction

   function automatic lim_t round_const(input int shift, input bit round);
      if (round && (shift > 0)) return LIM_ONE <<< (shift - 1);
      return LIM_ZERO;
   endfunction

endpackage

// File: rtl/fir_mul_round_sat.sv
// Combinational round / arithmetic shift / saturate-or-wrap stage applied to a full product.
// Shared with the accumulator; o_ovf flags any result whose value did not survive narrowing.
module fir_mul_round_sat
   import fir_mul_pkg::*;
#(
   parameter int P_WIDTH    = 27,
   parameter int DOUT_WIDTH = 26,
   parameter int SHIFT      = 0,
   parameter int ROUND      = 0,
   parameter int SAT        = 0,
   parameter int RES_SIGNED = 1
) (
   input  logic [P_WIDTH-1:0]    i_prod,
   output logic [DOUT_WIDTH-1:0] o_dout,
   output logic                  o_ovf
);

   // One guard bit so adding the rounding constant can never overflow the sum.
   localparam int   SW   = P_WIDTH + 1;
   localparam lim_t RC   = round_const(SHIFT, ROUND != 0);
   localparam lim_t MAXV = lim_max(DOUT_WIDTH, RES_SIGNED != 0);
   localparam lim_t MINV = lim_min(DOUT_WIDTH, RES_SIGNED != 0);

   logic signed [SW-1:0] w_sum;
   logic signed [SW-1:0] w_shr;
   lim_t                 w_r;
   logic                 w_hi;
   logic                 w_lo;

   assign w_sum = $signed({i_prod[P_WIDTH-1], i_prod}) + $signed(RC[SW-1:0]);
   assign w_shr = w_sum >>> SHIFT;
   assign w_r   = lim_t'(w_shr);

   assign w_hi  = (w_r > MAXV);
   assign w_lo  = (w_r < MINV);
   assign o_ovf = w_hi | w_lo;

   always_comb begin
      o_dout = w_r[DOUT_WIDTH-1:0];
      if (SAT != 0) begin
         if (w_hi)      o_dout = MAXV[DOUT_WIDTH-1:0];
         else if (w_lo) o_dout = MINV[DOUT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/fir_hls_mul_pipe.sv
// Pipelined multiplier with valid/ready backpressure, optional round/shift/saturate and sticky overflow.
// Multiply happens at the input; products ride NUM_STAGE-1 registers, then round/sat feeds the output register.
module fir_hls_mul_pipe
   import fir_mul_pkg::*;
#(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 2,
   parameter int din0_WIDTH = 14,
   parameter int din1_WIDTH = 12,
   parameter int dout_WIDTH = 26,
   parameter int SIGNED0    = 1,
   parameter int SIGNED1    = 0,
   parameter int SHIFT      = 0,
   parameter int ROUND      = 0,
   parameter int SAT        = 0
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  din_valid,
   output logic                  din_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  dout_ovf,
   output logic                  ovf_sticky,
   input  logic                  ovf_clr
);

   localparam int P          = prod_width(din0_WIDTH, din1_WIDTH);
   localparam int RES_SIGNED = ((SIGNED0 != 0) || (SIGNED1 != 0)) ? 1 : 0;

   logic signed [P-1:0]   w_a;
   logic signed [P-1:0]   w_b;
   logic signed [P-1:0]   w_prod;
   logic signed [P-1:0]   w_rs_in;
   logic [dout_WIDTH-1:0] w_rs_dout;
   logic                  w_rs_ovf;
   logic [NUM_STAGE-1:0]  w_vld_nxt;
   logic                  w_adv;
   logic                  w_set;

   logic [NUM_STAGE-1:0]  r_vld;
   logic [dout_WIDTH-1:0] r_dout;
   logic                  r_ovf;
   logic                  r_sticky;

   generate
      if (SIGNED0 != 0) begin : g_a_s
         assign w_a = P'($signed(din0));
      end else begin : g_a_u
         assign w_a = P'(din0);
      end
      if (SIGNED1 != 0) begin : g_b_s
         assign w_b = P'($signed(din1));
      end else begin : g_b_u
         assign w_b = P'(din1);
      end
   endgenerate

   // Both operands fit a signed P-bit form, so the P-bit signed product is exact.
   assign w_prod = w_a * w_b;

   assign w_adv     = !r_vld[NUM_STAGE-1] || dout_ready;
   assign din_ready = w_adv;

   generate
      if (NUM_STAGE == 1) begin : g_one
         assign w_vld_nxt = din_valid;
         assign w_rs_in   = w_prod;
      end else begin : g_multi
         logic signed [P-1:0] r_prod [NUM_STAGE-1];

         assign w_vld_nxt = {r_vld[NUM_STAGE-2:0], din_valid};
         assign w_rs_in   = r_prod[NUM_STAGE-2];

         always_ff @(posedge ap_clk) begin
            if (w_adv && din_valid) r_prod[0] <= w_prod;
            for (int i = 1; i < NUM_STAGE - 1; i++) begin
               if (w_adv && r_vld[i-1]) r_prod[i] <= r_prod[i-1];
            end
         end
      end
   endgenerate

   fir_mul_round_sat #(
      .P_WIDTH    (P),
      .DOUT_WIDTH (dout_WIDTH),
      .SHIFT      (SHIFT),
      .ROUND      (ROUND),
      .SAT        (SAT),
      .RES_SIGNED (RES_SIGNED)
   ) u_round_sat (
      .i_prod (w_rs_in),
      .o_dout (w_rs_dout),
      .o_ovf  (w_rs_ovf)
   );

   // dout holds across bubbles; dout_ovf is qualified by the incoming valid bit.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         r_vld  <= '0;
         r_dout <= '0;
         r_ovf  <= 1'b0;
      end else if (w_adv) begin
         r_vld <= w_vld_nxt;
         r_ovf <= w_vld_nxt[NUM_STAGE-1] & w_rs_ovf;
         if (w_vld_nxt[NUM_STAGE-1]) r_dout <= w_rs_dout;
      end
   end

   assign w_set = r_vld[NUM_STAGE-1] & dout_ready & r_ovf;

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst)       r_sticky <= 1'b0;
      else if (w_set)   r_sticky <= 1'b1;
      else if (ovf_clr) r_sticky <= 1'b0;
   end

   assign dout_valid = r_vld[NUM_STAGE-1];
   assign dout       = r_dout;
   assign dout_ovf   = r_ovf;
   assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_fir_hls_mul_pipe.sv
// Directed bench for fir_hls_mul_pipe: five parameterisations share one clock, reset and ovf_clr.
module tb_fir_hls_mul_pipe;

   logic clk = 1'b0;
   logic rst;
   logic ovf_clr;
   int   tests_run = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   // default legacy core
   logic def_vld, def_rdy, def_ov, def_dr, def_of, def_st;
   logic [13:0] def_a;
   logic [11:0] def_b;
   logic signed [25:0] def_q;
   // SHIFT=4, ROUND=1
   logic rnd_vld, rnd_rdy, rnd_ov, rnd_dr, rnd_of, rnd_st;
   logic [13:0] rnd_a;
   logic [11:0] rnd_b;
   logic signed [25:0] rnd_q;
   // SAT=1, 16-bit output
   logic sat_vld, sat_rdy, sat_ov, sat_dr, sat_of, sat_st;
   logic [13:0] sat_a;
   logic [11:0] sat_b;
   logic [15:0] sat_q;
   // NUM_STAGE=3 streaming
   logic st3_vld, st3_rdy, st3_ov, st3_dr, st3_of, st3_st;
   logic [13:0] st3_a;
   logic [11:0] st3_b;
   logic [25:0] st3_q;
   // unsigned x unsigned, 8-bit wrap
   logic uns_vld, uns_rdy, uns_ov, uns_dr, uns_of, uns_st;
   logic [13:0] uns_a;
   logic [11:0] uns_b;
   logic [7:0]  uns_q;

   fir_hls_mul_pipe u_def (
      .ap_clk(clk), .ap_rst(rst), .din_valid(def_vld), .din_ready(def_rdy),
      .din0(def_a), .din1(def_b), .dout_valid(def_ov), .dout_ready(def_dr),
      .dout(def_q), .dout_ovf(def_of), .ovf_sticky(def_st), .ovf_clr(ovf_clr));

   fir_hls_mul_pipe #(.SHIFT(4), .ROUND(1)) u_rnd (
      .ap_clk(clk), .ap_rst(rst), .din_valid(rnd_vld), .din_ready(rnd_rdy),
      .din0(rnd_a), .din1(rnd_b), .dout_valid(rnd_ov), .dout_ready(rnd_dr),
      .dout(rnd_q), .dout_ovf(rnd_of), .ovf_sticky(rnd_st), .ovf_clr(ovf_clr));

   fir_hls_mul_pipe #(.dout_WIDTH(16), .SAT(1)) u_sat (
      .ap_clk(clk), .ap_rst(rst), .din_valid(sat_vld), .din_ready(sat_rdy),
      .din0(sat_a), .din1(sat_b), .dout_valid(sat_ov), .dout_ready(sat_dr),
      .dout(sat_q), .dout_ovf(sat_of), .ovf_sticky(sat_st), .ovf_clr(ovf_clr));

   fir_hls_mul_pipe #(.NUM_STAGE(3)) u_st3 (
      .ap_clk(clk), .ap_rst(rst), .din_valid(st3_vld), .din_ready(st3_rdy),
      .din0(st3_a), .din1(st3_b), .dout_valid(st3_ov), .dout_ready(st3_dr),
      .dout(st3_q), .dout_ovf(st3_of), .ovf_sticky(st3_st), .ovf_clr(ovf_clr));

   fir_hls_mul_pipe #(.SIGNED0(0), .SIGNED1(0), .dout_WIDTH(8)) u_uns (
      .ap_clk(clk), .ap_rst(rst), .din_valid(uns_vld), .din_ready(uns_rdy),
      .din0(uns_a), .din1(uns_b), .dout_valid(uns_ov), .dout_ready(uns_dr),
      .dout(uns_q), .dout_ovf(uns_of), .ovf_sticky(uns_st), .ovf_clr(ovf_clr));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; ovf_clr = 1'b0;
      def_vld = 0; def_a = '0; def_b = '0; def_dr = 1;
      rnd_vld = 0; rnd_a = '0; rnd_b = '0; rnd_dr = 1;
      sat_vld = 0; sat_a = '0; sat_b = '0; sat_dr = 1;
      st3_vld = 0; st3_a = '0; st3_b = '0; st3_dr = 1;
      uns_vld = 0; uns_a = '0; uns_b = '0; uns_dr = 1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      tests_run++;
      if (def_ov !== 1'b0 || def_q !== 26'sd0) begin
         tests_failed++; $display("FAIL reset_def_out: valid=%b dout=%0d, want 0/0", def_ov, def_q);
      end
      tests_run++;
      if (def_of !== 1'b0 || def_st !== 1'b0) begin
         tests_failed++; $display("FAIL reset_def_ovf: ovf=%b sticky=%b, want 0/0", def_of, def_st);
      end
      tests_run++;
      if (def_rdy !== 1'b1) begin
         tests_failed++; $display("FAIL reset_din_ready: got %b want 1", def_rdy);
      end
      tests_run++;
      if ({rnd_ov, sat_ov, st3_ov, uns_ov} !== 4'b0000 || sat_q !== 16'h0000 || uns_q !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_others: valids=%b sat_q=%h uns_q=%h, want 0000/0/0",
                  {rnd_ov, sat_ov, st3_ov, uns_ov}, sat_q, uns_q);
      end
   endtask

   task automatic test_default;
      def_vld = 1; def_a = 14'h3FFD; def_b = 12'd5;   // -3 * 5
      tick();
      tests_run++;
      if (def_ov !== 1'b0) begin
         tests_failed++; $display("FAIL def_latency_early: valid=%b after 1 edge, want 0", def_ov);
      end
      def_a = 14'h2000; def_b = 12'd4095;              // -8192 * 4095
      tick();
      def_vld = 0;
      tests_run++;
      if (def_ov !== 1'b1 || def_q !== -26'sd15 || def_of !== 1'b0) begin
         tests_failed++; $display("FAIL def_first: valid=%b dout=%0d ovf=%b, want 1/-15/0", def_ov, def_q, def_of);
      end
      tick();
      tests_run++;
      if (def_ov !== 1'b1 || def_q !== -26'sd33546240 || def_of !== 1'b0) begin
         tests_failed++;
         $display("FAIL def_min_x_max: valid=%b dout=%0d ovf=%b, want 1/-33546240/0", def_ov, def_q, def_of);
      end
      tick();
      tests_run++;
      if (def_ov !== 1'b0) begin
         tests_failed++; $display("FAIL def_drain: valid=%b, want 0", def_ov);
      end
   endtask

   task automatic test_backpressure;
      def_dr = 0; def_vld = 1; def_a = 14'd11; def_b = 12'd11;
      tick();
      def_vld = 0;
      tick();
      tests_run++;
      if (def_ov !== 1'b1 || def_q !== 26'sd121 || def_rdy !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_stall_entry: valid=%b dout=%0d din_ready=%b, want 1/121/0", def_ov, def_q, def_rdy);
      end
      def_vld = 1; def_a = 14'd2; def_b = 12'd3;
      for (int k = 0; k < 3; k++) begin
         tick();
         tests_run++;
         if (def_ov !== 1'b1 || def_q !== 26'sd121 || def_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_hold[%0d]: valid=%b dout=%0d din_ready=%b, want 1/121/0", k, def_ov, def_q, def_rdy);
         end
      end
      def_dr = 1;
      tick();
      def_vld = 0;
      tests_run++;
      if (def_ov !== 1'b0) begin
         tests_failed++; $display("FAIL bp_release_bubble: valid=%b, want 0", def_ov);
      end
      tick();
      tests_run++;
      if (def_ov !== 1'b1 || def_q !== 26'sd6) begin
         tests_failed++; $display("FAIL bp_held_pair: valid=%b dout=%0d, want 1/6", def_ov, def_q);
      end
      tick();
      tests_run++;
      if (def_ov !== 1'b0) begin
         tests_failed++; $display("FAIL bp_no_duplicate: valid=%b, want 0", def_ov);
      end
   endtask

   task automatic test_round;
      rnd_vld = 1; rnd_a = 14'd24; rnd_b = 12'd1;
      tick();
      rnd_a = 14'h3FE8; rnd_b = 12'd1;                 // -24
      tick();
      tests_run++;
      if (rnd_ov !== 1'b1 || rnd_q !== 26'sd2) begin
         tests_failed++; $display("FAIL round_pos24: valid=%b dout=%0d, want 1/2", rnd_ov, rnd_q);
      end
      rnd_a = 14'd23; rnd_b = 12'd1;
      tick();
      rnd_vld = 0;
      tests_run++;
      if (rnd_ov !== 1'b1 || rnd_q !== -26'sd1) begin
         tests_failed++; $display("FAIL round_neg24: valid=%b dout=%0d, want 1/-1", rnd_ov, rnd_q);
      end
      tick();
      tests_run++;
      if (rnd_ov !== 1'b1 || rnd_q !== 26'sd1 || rnd_of !== 1'b0) begin
         tests_failed++; $display("FAIL round_pos23: valid=%b dout=%0d ovf=%b, want 1/1/0", rnd_ov, rnd_q, rnd_of);
      end
   endtask

   task automatic test_saturate;
      sat_vld = 1; sat_a = 14'h1FFF; sat_b = 12'd4095; // 8191 * 4095
      tick();
      sat_a = 14'h2000; sat_b = 12'd4095;              // -8192 * 4095
      tick();
      sat_vld = 0;
      tests_run++;
      if (sat_ov !== 1'b1 || sat_q !== 16'h7FFF || sat_of !== 1'b1 || sat_st !== 1'b0) begin
         tests_failed++;
         $display("FAIL sat_max: valid=%b dout=%h ovf=%b sticky=%b, want 1/7fff/1/0", sat_ov, sat_q, sat_of, sat_st);
      end
      tick();
      tests_run++;
      if (sat_ov !== 1'b1 || sat_q !== 16'h8000 || sat_of !== 1'b1 || sat_st !== 1'b1) begin
         tests_failed++;
         $display("FAIL sat_min: valid=%b dout=%h ovf=%b sticky=%b, want 1/8000/1/1", sat_ov, sat_q, sat_of, sat_st);
      end
      ovf_clr = 1;
      tick();
      tests_run++;
      if (sat_st !== 1'b1 || sat_ov !== 1'b0) begin
         tests_failed++; $display("FAIL sat_set_wins: sticky=%b valid=%b, want 1/0", sat_st, sat_ov);
      end
      tick();
      ovf_clr = 0;
      tests_run++;
      if (sat_st !== 1'b0) begin
         tests_failed++; $display("FAIL sat_clear: sticky=%b, want 0", sat_st);
      end
   endtask

   task automatic test_unsigned_wrap;
      uns_vld = 1; uns_a = 14'd16; uns_b = 12'd16;
      tick();
      uns_a = 14'd15; uns_b = 12'd17;
      tick();
      uns_vld = 0;
      tests_run++;
      if (uns_ov !== 1'b1 || uns_q !== 8'd0 || uns_of !== 1'b1) begin
         tests_failed++; $display("FAIL wrap_256: valid=%b dout=%0d ovf=%b, want 1/0/1", uns_ov, uns_q, uns_of);
      end
      tick();
      tests_run++;
      if (uns_ov !== 1'b1 || uns_q !== 8'd255 || uns_of !== 1'b0 || uns_st !== 1'b1) begin
         tests_failed++;
         $display("FAIL wrap_255: valid=%b dout=%0d ovf=%b sticky=%b, want 1/255/0/1", uns_ov, uns_q, uns_of, uns_st);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0]  lfsr;
      logic [25:0] held_q;
      logic        held;
      int          got;
      int          stalls;
      int          cyc;
      lfsr = 8'hA5; held = 0; held_q = '0; got = 0; stalls = 0; cyc = 0;
      fork
         begin : producer
            for (int k = 1; k <= 10; k++) begin
               logic acc;
               int   guard;
               st3_vld = 1; st3_a = 14'(k); st3_b = 12'd2;
               acc = 0; guard = 0;
               while (!acc && guard < 100) begin
                  @(negedge clk);
                  acc = st3_rdy;
                  @(posedge clk);
                  #1;
                  guard++;
               end
               if (!acc) begin
                  tests_run++; tests_failed++;
                  $display("FAIL stream_accept_timeout: item %0d not accepted, want accepted", k);
               end
            end
            st3_vld = 0;
         end
         begin : consumer
            while (got < 10 && cyc < 300) begin
               lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
               st3_dr = lfsr[0];
               @(negedge clk);
               if (held) begin
                  tests_run++;
                  if (st3_ov !== 1'b1 || st3_q !== held_q) begin
                     tests_failed++;
                     $display("FAIL stream_stall_hold: valid=%b dout=%0d, want 1/%0d", st3_ov, st3_q, held_q);
                  end
               end
               if (st3_ov === 1'b1 && st3_dr === 1'b1) begin
                  tests_run++;
                  if (st3_q !== 26'(2 * (got + 1))) begin
                     tests_failed++;
                     $display("FAIL stream_value[%0d]: dout=%0d, want %0d", got, st3_q, 2 * (got + 1));
                  end
                  got++;
                  held = 0;
               end else if (st3_ov === 1'b1) begin
                  held = 1; held_q = st3_q; stalls++;
               end else begin
                  held = 0;
               end
               @(posedge clk);
               #1;
               cyc++;
            end
         end
      join
      tests_run++;
      if (got != 10) begin
         tests_failed++; $display("FAIL stream_count: received %0d results, want 10", got);
      end
      tests_run++;
      if (stalls == 0) begin
         tests_failed++; $display("FAIL stream_stalls: observed %0d stalls, want >0", stalls);
      end
      st3_dr = 1;
      repeat (4) tick();
      tests_run++;
      if (st3_ov !== 1'b0) begin
         tests_failed++; $display("FAIL stream_extra: valid=%b dout=%0d after drain, want 0", st3_ov, st3_q);
      end
   endtask

   task automatic test_reset_midflight;
      def_dr = 1; def_vld = 1; def_a = 14'd100; def_b = 12'd3;
      tick();
      def_a = 14'd200;
      tick();
      def_vld = 0;
      tests_run++;
      if (def_ov !== 1'b1 || def_q !== 26'sd300) begin
         tests_failed++; $display("FAIL rst_pre: valid=%b dout=%0d, want 1/300", def_ov, def_q);
      end
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if (def_ov !== 1'b0 || def_q !== 26'sd0) begin
         tests_failed++; $display("FAIL rst_async: valid=%b dout=%0d, want 0/0", def_ov, def_q);
      end
      tick();
      rst = 1'b0;
      def_vld = 1; def_a = 14'h3FFB; def_b = 12'd9;   // -5 * 9
      tick();
      def_vld = 0;
      tests_run++;
      if (def_ov !== 1'b0) begin
         tests_failed++; $display("FAIL rst_residue: valid=%b dout=%0d, want 0", def_ov, def_q);
      end
      tick();
      tests_run++;
      if (def_ov !== 1'b1 || def_q !== -26'sd45) begin
         tests_failed++; $display("FAIL rst_first_new: valid=%b dout=%0d, want 1/-45", def_ov, def_q);
      end
      tick();
      tests_run++;
      if (def_ov !== 1'b0) begin
         tests_failed++; $display("FAIL rst_drain: valid=%b, want 0", def_ov);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_default();
      test_backpressure();
      test_round();
      test_saturate();
      test_unsigned_wrap();
      test_back_to_back();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
